// File: rtl/pulse_transition.sv
`default_nettype none
// ============================================================================
// pulse_transition : periodic pulse plus a signed, slew-limited output level.
// Optional macro PULSE_TRANSITION_SETTLED_EN adds a registered settled flag.
// Revision 1.0
// ============================================================================
module pulse_transition #(
    parameter int PERIOD_CYC = 40,
    parameter int WIDTH_CYC  = 20,
    parameter int DATA_W     = 16,
    parameter int VALUE0     = -512,
    parameter int VALUE1     = 512,
    parameter int RISE_CYC   = 4,
    parameter int FALL_CYC   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic                     pulse,
    output logic signed [DATA_W-1:0] out
`ifdef PULSE_TRANSITION_SETTLED_EN
    ,
    output logic                     settled
`endif
);

    localparam int CNT_W  = $clog2(PERIOD_CYC);
    localparam int c_VMIN = -(2 ** (DATA_W - 1));
    localparam int c_VMAX = (2 ** (DATA_W - 1)) - 1;
    localparam int c_DIFF = (VALUE1 > VALUE0) ? (VALUE1 - VALUE0) : (VALUE0 - VALUE1);
    localparam int c_RSTEP_I = (RISE_CYC == 0) ? c_DIFF : (c_DIFF + RISE_CYC - 1) / RISE_CYC;
    localparam int c_FSTEP_I = (FALL_CYC == 0) ? c_DIFF : (c_DIFF + FALL_CYC - 1) / FALL_CYC;

    localparam logic [CNT_W-1:0]        c_WIDTH = CNT_W'(WIDTH_CYC);
    localparam logic [CNT_W-1:0]        c_LAST  = CNT_W'(PERIOD_CYC - 1);
    localparam logic signed [DATA_W:0]  c_V0    = (DATA_W + 1)'(VALUE0);
    localparam logic signed [DATA_W:0]  c_V1    = (DATA_W + 1)'(VALUE1);
    localparam logic signed [DATA_W:0]  c_RSTEP = (DATA_W + 1)'(c_RSTEP_I);
    localparam logic signed [DATA_W:0]  c_FSTEP = (DATA_W + 1)'(c_FSTEP_I);

    if (PERIOD_CYC < 2) begin : g_bad_period
        $error("pulse_transition: PERIOD_CYC must be 2 or more");
    end
    if (WIDTH_CYC < 1 || WIDTH_CYC >= PERIOD_CYC) begin : g_bad_width
        $error("pulse_transition: WIDTH_CYC must be in 1..PERIOD_CYC-1");
    end
    if (VALUE0 < c_VMIN || VALUE0 > c_VMAX) begin : g_bad_value0
        $error("pulse_transition: VALUE0 outside DATA_W range");
    end
    if (VALUE1 < c_VMIN || VALUE1 > c_VMAX) begin : g_bad_value1
        $error("pulse_transition: VALUE1 outside DATA_W range");
    end

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pulse_q, pulse_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic signed [DATA_W:0]   w_cur, w_tgt, w_step, w_rem, w_next;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (en) begin
            pulse_d = (cnt_q < c_WIDTH);
            cnt_d   = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
        end

        // Clamp by comparing the step with the remaining distance, so the
        // sum is only formed when it cannot pass the target.
        w_cur  = {out_q[DATA_W-1], out_q};
        w_tgt  = pulse_q ? c_V1 : c_V0;
        w_step = pulse_q ? c_RSTEP : c_FSTEP;
        w_rem  = '0;
        w_next = w_cur;
        if (w_cur < w_tgt) begin
            w_rem  = w_tgt - w_cur;
            w_next = (w_step >= w_rem) ? w_tgt : w_cur + w_step;
        end else if (w_cur > w_tgt) begin
            w_rem  = w_cur - w_tgt;
            w_next = (w_step >= w_rem) ? w_tgt : w_cur - w_step;
        end
        out_d = DATA_W'(w_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            out_q   <= DATA_W'(c_V0);
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            out_q   <= out_d;
        end
    end

    assign pulse = pulse_q;
    assign out   = out_q;

`ifdef PULSE_TRANSITION_SETTLED_EN
    logic settled_q, settled_d;

    // High when this cycle's update landed on the target it was heading for.
    assign settled_d = (w_next == w_tgt);

    always_ff @(posedge clk) begin
        if (rst) begin
            settled_q <= 1'b1;
        end else begin
            settled_q <= settled_d;
        end
    end

    assign settled = settled_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_transition.sv
`default_nettype none
// ============================================================================
// tb_pulse_transition : self-checking bench for pulse_transition (three
// parameter sets against a behavioural model). Revision 1.0
// ============================================================================
module tb_pulse_transition;

    localparam int NDUT = 3;
    localparam int V0   = -512;
    localparam int V1   = 512;
    // Instance 0: defaults; 1: short period for reversal; 2: instant steps
    localparam int P_PER[NDUT]  = '{40, 4, 40};
    localparam int P_WID[NDUT]  = '{20, 2, 20};
    localparam int P_RISE[NDUT] = '{4, 4, 0};
    localparam int P_FALL[NDUT] = '{2, 2, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic p_a, p_b, p_c;
    logic signed [15:0] o_a, o_b, o_c;
`ifdef PULSE_TRANSITION_SETTLED_EN
    logic s_a, s_b, s_c;
`endif

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    int m_cnt[NDUT];
    int m_pulse[NDUT];
    int m_out[NDUT];
    int m_set[NDUT];

    always #5 clk = ~clk;

    pulse_transition u_a (
        .clk(clk), .rst(rst), .en(en), .pulse(p_a), .out(o_a)
`ifdef PULSE_TRANSITION_SETTLED_EN
        , .settled(s_a)
`endif
    );

    pulse_transition #(.PERIOD_CYC(4), .WIDTH_CYC(2)) u_b (
        .clk(clk), .rst(rst), .en(en), .pulse(p_b), .out(o_b)
`ifdef PULSE_TRANSITION_SETTLED_EN
        , .settled(s_b)
`endif
    );

    pulse_transition #(.RISE_CYC(0), .FALL_CYC(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .pulse(p_c), .out(o_c)
`ifdef PULSE_TRANSITION_SETTLED_EN
        , .settled(s_c)
`endif
    );

    function automatic int get_pulse(int i);
        case (i)
            0:       return int'(p_a);
            1:       return int'(p_b);
            default: return int'(p_c);
        endcase
    endfunction

    function automatic int get_out(int i);
        case (i)
            0:       return int'(o_a);
            1:       return int'(o_b);
            default: return int'(o_c);
        endcase
    endfunction

`ifdef PULSE_TRANSITION_SETTLED_EN
    function automatic int get_set(int i);
        case (i)
            0:       return int'(s_a);
            1:       return int'(s_b);
            default: return int'(s_c);
        endcase
    endfunction
`endif

    function automatic int ceil_div(int a, int b);
        return (b == 0) ? a : (a + b - 1) / b;
    endfunction

    // Reference: phase counter by modulo arithmetic, level moves toward the
    // target chosen by last cycle's pulse by at most one step.
    function automatic void model_step(int i, bit r, bit e);
        int span, step, tgt, nxt;
        if (r) begin
            m_cnt[i] = 0; m_pulse[i] = 0; m_out[i] = V0; m_set[i] = 1;
            return;
        end
        span = (V1 > V0) ? V1 - V0 : V0 - V1;
        tgt  = m_pulse[i] ? V1 : V0;
        step = m_pulse[i] ? ceil_div(span, P_RISE[i]) : ceil_div(span, P_FALL[i]);
        nxt  = m_out[i];
        if (nxt < tgt)      nxt = (tgt - nxt <= step) ? tgt : nxt + step;
        else if (nxt > tgt) nxt = (nxt - tgt <= step) ? tgt : nxt - step;
        m_out[i] = nxt;
        m_set[i] = (nxt == tgt) ? 1 : 0;
        if (e) begin
            m_pulse[i] = (m_cnt[i] < P_WID[i]) ? 1 : 0;
            m_cnt[i]   = (m_cnt[i] + 1) % P_PER[i];
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising.
    task automatic cyc(input bit r, input bit e);
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_step(i, r, e);
        #1;
        ncyc++;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("model_pulse[%0d]", i), get_pulse(i), m_pulse[i]);
            check($sformatf("model_out[%0d]", i), get_out(i), m_out[i]);
`ifdef PULSE_TRANSITION_SETTLED_EN
            check($sformatf("model_settled[%0d]", i), get_set(i), m_set[i]);
`endif
        end
    endtask

    typedef struct {
        bit r;
        bit e;
        int pa;
        int oa;
        int ob;
        int oc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int hi;
        bit r, e;

        // Two reset cycles then enabled edges 1..6 after release
        tbl[0] = '{1, 0, 0, -512, -512, -512};
        tbl[1] = '{1, 1, 0, -512, -512, -512};
        tbl[2] = '{0, 1, 1, -512, -512, -512};
        tbl[3] = '{0, 1, 1, -256, -256,  512};
        tbl[4] = '{0, 1, 1,    0,    0,  512};
        tbl[5] = '{0, 1, 1,  256, -512,  512};
        tbl[6] = '{0, 1, 1,  512, -512,  512};
        tbl[7] = '{0, 1, 1,  512, -256,  512};

        for (int k = 0; k < 8; k++) begin
            cyc(tbl[k].r, tbl[k].e);
            check($sformatf("tbl%0d_pulse_a", k), int'(p_a), tbl[k].pa);
            check($sformatf("tbl%0d_out_a", k), int'(o_a), tbl[k].oa);
            check($sformatf("tbl%0d_out_b", k), int'(o_b), tbl[k].ob);
            check($sformatf("tbl%0d_out_c", k), int'(o_c), tbl[k].oc);
        end

        // Fall edge and period with defaults: now at edge 6
        for (int k = 7; k <= 41; k++) begin
            cyc(0, 1);
            if (k == 20) check("edge20_pulse", int'(p_a), 1);
            if (k == 21) check("edge21_pulse", int'(p_a), 0);
            if (k == 22) check("edge22_out", int'(o_a), 0);
            if (k == 22) check("edge22_out_instant", int'(o_c), -512);
            if (k == 23) check("edge23_out", int'(o_a), -512);
            if (k == 40) check("edge40_pulse", int'(p_a), 0);
            if (k == 41) check("edge41_pulse", int'(p_a), 1);
        end

        // Enable gap of 10 cycles starting at edge 7
        cyc(1, 0);
        for (int k = 1; k <= 6; k++) cyc(0, 1);
        for (int k = 7; k <= 16; k++) begin
            cyc(0, 0);
            check("gap_pulse_hold", int'(p_a), 1);
        end
        check("gap_out_settled", int'(o_a), 512);
        hi = 6;
        for (int k = 0; k < 40; k++) begin
            cyc(0, 1);
            if (p_a != 1'b1) break;
            hi++;
        end
        check("gap_high_total", hi, 20);

        // Reset mid-ramp at edge 3
        cyc(1, 0);
        cyc(0, 1);
        cyc(0, 1);
        cyc(1, 1);
        check("midreset_out", int'(o_a), -512);
        check("midreset_pulse", int'(p_a), 0);
`ifdef PULSE_TRANSITION_SETTLED_EN
        check("midreset_settled", int'(s_a), 1);
`endif
        cyc(0, 1);
        check("postreset_pulse", int'(p_a), 1);

        // Randomized enable and occasional reset against the model
        for (int k = 0; k < 3000; k++) begin
            e = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 199) == 0);
            cyc(r, e);
`ifdef PULSE_TRANSITION_SETTLED_EN
            check("instant_settled_high", int'(s_c), 1);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
